// File: rtl/instr_packer_if.sv
// -----------------------------------------------------------------------------
// instr_packer_if
//   Bundles the field-input handshake and the packed-word output handshake of
//   instr_packer.
//
//   Input side : in_valid/in_ready plus immsrc, imm, opcode, funct3, rd, rs1, rs2
//   Output side: out_valid/out_ready plus out_instr, out_addr, out_err
//   Status     : err_seen (sticky error flag since reset)
//
//   slave  - the packer itself
//   master - whoever feeds fields and consumes packed words (loader / bench)
// -----------------------------------------------------------------------------
interface instr_packer_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       immsrc;
    logic [WIDTH-1:0] imm;
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic [4:0]       rd;
    logic [4:0]       rs1;
    logic [4:0]       rs2;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_instr;
    logic [WIDTH-1:0] out_addr;
    logic             out_err;

    logic             err_seen;

    modport slave (
        input  in_valid, immsrc, imm, opcode, funct3, rd, rs1, rs2, out_ready,
        output in_ready, out_valid, out_instr, out_addr, out_err, err_seen
    );

    modport master (
        output in_valid, immsrc, imm, opcode, funct3, rd, rs1, rs2, out_ready,
        input  in_ready, out_valid, out_instr, out_addr, out_err, err_seen
    );
endinterface

// File: rtl/instr_packer.sv
// -----------------------------------------------------------------------------
// instr_packer
//   Immediate encoder and RV32I instruction word packer for the program-loading
//   path. Range-checks a 32-bit signed immediate, scatters it into the I, S or
//   B format selected by immsrc, and queues {word, byte address, error} in a
//   2-entry in-order FIFO. Error entries carry a NOP word but still consume an
//   address slot so the program layout is preserved.
//
//   Ports:
//     clk  - clock, all state updates on the rising edge
//     rst  - synchronous active-high reset
//     bus  - instr_packer_if.slave (field input, packed-word output, err_seen)
//
//   FIFO organisation: head_q is the presented entry and drives the outputs
//   directly (so they hold their last value when empty), tail_q is the second
//   slot. in_ready and out_valid come straight from count_q.
// -----------------------------------------------------------------------------
module instr_packer #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] BASE_ADDR = '0
) (
    input  logic          clk,
    input  logic          rst,
    instr_packer_if.slave bus
);
    localparam logic [WIDTH-1:0] NOP_WORD = WIDTH'(32'h0000_0013);

    typedef enum logic [1:0] {
        FMT_I   = 2'b00,
        FMT_S   = 2'b01,
        FMT_B   = 2'b10,
        FMT_RSV = 2'b11
    } fmt_e;

    typedef struct packed {
        logic [WIDTH-1:0] instr;
        logic [WIDTH-1:0] addr;
        logic             err;
    } entry_t;

    logic [1:0]       count_q;
    entry_t           head_q;
    entry_t           tail_q;
    logic [WIDTH-1:0] addr_q;
    logic             err_seen_q;

    logic             in_ready;
    logic             push;
    logic             pop;
    logic             fits_12;
    logic             fits_13;
    logic [WIDTH-1:0] enc_word;
    logic             enc_err;
    entry_t           new_entry;

    // ---------------------------------------------------------------- encoder
    // Sign bits above the field must all match the field's top bit.
    assign fits_12 = (&bus.imm[WIDTH-1:11]) | ~(|bus.imm[WIDTH-1:11]);
    assign fits_13 = (&bus.imm[WIDTH-1:12]) | ~(|bus.imm[WIDTH-1:12]);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case can leave it unassigned and infer a latch.
        enc_word = NOP_WORD;
        enc_err  = 1'b1;
        case (fmt_e'(bus.immsrc))
            FMT_I: begin
                if (fits_12) begin
                    enc_word = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};
                    enc_err  = 1'b0;
                end
            end
            FMT_S: begin
                if (fits_12) begin
                    enc_word = {bus.imm[11:5], bus.rs2, bus.rs1, bus.funct3,
                                bus.imm[4:0], bus.opcode};
                    enc_err  = 1'b0;
                end
            end
            FMT_B: begin
                // Branch offsets are halfword aligned; bit 0 is not encoded.
                if (fits_13 && !bus.imm[0]) begin
                    enc_word = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                                bus.imm[4:1], bus.imm[11], bus.opcode};
                    enc_err  = 1'b0;
                end
            end
            default: ;  // reserved format keeps the NOP/error defaults
        endcase
    end

    assign new_entry = '{instr: enc_word, addr: addr_q, err: enc_err};

    // -------------------------------------------------------------- handshake
    // in_ready depends only on count_q: a pop while full frees the slot for
    // the next cycle, never the current one.
    assign in_ready = (count_q != 2'd2);
    assign push     = bus.in_valid & in_ready;
    assign pop      = (count_q != 2'd0) & bus.out_ready;

    // ------------------------------------------------------- control + head
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            count_q    <= 2'd0;
            head_q     <= '{instr: '0, addr: BASE_ADDR, err: 1'b0};
            addr_q     <= BASE_ADDR;
            err_seen_q <= 1'b0;
        end else begin
            if (push) begin
                addr_q <= addr_q + WIDTH'(4);  // wraps modulo 2^WIDTH
                if (enc_err) begin
                    err_seen_q <= 1'b1;
                end
            end

            case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        head_q <= new_entry;
                    end
                    count_q <= count_q + 2'd1;
                end
                2'b01: begin
                    if (count_q == 2'd2) begin
                        head_q <= tail_q;
                    end
                    count_q <= count_q - 2'd1;
                end
                // Push and pop together only happen with exactly one entry:
                // the new entry replaces the head and the count is unchanged.
                2'b11: head_q <= new_entry;
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------ tail slot
    // NOTE: tail_q is a data slot, not control; count_q says whether it holds
    // anything, so it is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (!rst && push && !pop && count_q == 2'd1) begin
            tail_q <= new_entry;
        end
    end

    // -------------------------------------------------------------- outputs
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (count_q != 2'd0);
    assign bus.out_instr = head_q.instr;
    assign bus.out_addr  = head_q.addr;
    assign bus.out_err   = head_q.err;
    assign bus.err_seen  = err_seen_q;
endmodule

// File: tb/tb_instr_packer.sv
// -----------------------------------------------------------------------------
// tb_instr_packer
//   Self-checking bench for instr_packer. A queue-based model tracks accepted
//   entries; a compare process checks handshake, head fields and err_seen on
//   every falling edge. Directed sequences pin the model with literal values,
//   then a randomized phase exercises formats, ranges, backpressure and reset.
// -----------------------------------------------------------------------------
module tb_instr_packer;
    localparam logic [31:0] BASE = 32'h0000_0000;

    logic clk;
    logic rst;

    instr_packer_if #(.WIDTH(32)) bus ();

    instr_packer #(.WIDTH(32), .BASE_ADDR(BASE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // --------------------------------------------------------------- model
    typedef struct {
        logic [31:0] instr;
        logic [31:0] addr;
        logic        err;
    } exp_t;

    exp_t        mq[$];
    logic [31:0] m_addr;
    logic        m_err_seen;
    bit          cmp_en;
    bit          m_push;
    bit          m_pop;
    exp_t        m_e;

    // Encoding computed from field positions with shifts/masks and signed
    // range comparisons.
    function automatic logic [31:0] ref_encode(
        input logic [1:0] src, input logic [31:0] im, input logic [6:0] op,
        input logic [2:0] f3, input logic [4:0] rdv, input logic [4:0] r1,
        input logic [4:0] r2, output logic err);
        int          s;
        logic [31:0] w;
        s   = im;
        err = 1'b1;
        w   = 32'h0000_0013;
        case (src)
            2'd0: if (s >= -2048 && s <= 2047) begin
                err = 1'b0;
                w = ((im & 32'hFFF) << 20) | (32'(r1) << 15) | (32'(f3) << 12)
                  | (32'(rdv) << 7) | 32'(op);
            end
            2'd1: if (s >= -2048 && s <= 2047) begin
                err = 1'b0;
                w = (((im >> 5) & 32'h7F) << 25) | (32'(r2) << 20) | (32'(r1) << 15)
                  | (32'(f3) << 12) | ((im & 32'h1F) << 7) | 32'(op);
            end
            2'd2: if (s >= -4096 && s <= 4094 && (im & 32'h1) == 32'h0) begin
                err = 1'b0;
                w = (((im >> 12) & 32'h1) << 31) | (((im >> 5) & 32'h3F) << 25)
                  | (32'(r2) << 20) | (32'(r1) << 15) | (32'(f3) << 12)
                  | (((im >> 1) & 32'hF) << 8) | (((im >> 11) & 32'h1) << 7) | 32'(op);
            end
            default: ;
        endcase
        return w;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_addr     = BASE;
            m_err_seen = 1'b0;
        end else begin
            m_push = bus.in_valid && (mq.size() < 2);
            m_pop  = bus.out_ready && (mq.size() > 0);
            if (m_push) begin
                m_e.instr = ref_encode(bus.immsrc, bus.imm, bus.opcode, bus.funct3,
                                       bus.rd, bus.rs1, bus.rs2, m_e.err);
                m_e.addr  = m_addr;
                m_addr    = m_addr + 32'd4;
                if (m_e.err) m_err_seen = 1'b1;
            end
            if (m_pop) void'(mq.pop_front());
            if (m_push) mq.push_back(m_e);
        end
    end

    // ------------------------------------------------------------- compare
    always @(negedge clk) begin
        if (cmp_en) begin
            check("in_ready", 32'(bus.in_ready), 32'(mq.size() < 2));
            check("out_valid", 32'(bus.out_valid), 32'(mq.size() > 0));
            check("err_seen", 32'(bus.err_seen), 32'(m_err_seen));
            if (mq.size() > 0) begin
                check("out_instr", bus.out_instr, mq[0].instr);
                check("out_addr", bus.out_addr, mq[0].addr);
                check("out_err", 32'(bus.out_err), 32'(mq[0].err));
            end
        end
    end

    // ------------------------------------------------------------ stimulus
    task automatic drive(input logic v, input logic [1:0] src, input logic [31:0] im,
                         input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rdv,
                         input logic [4:0] r1, input logic [4:0] r2);
        bus.in_valid = v;
        bus.immsrc   = src;
        bus.imm      = im;
        bus.opcode   = op;
        bus.funct3   = f3;
        bus.rd       = rdv;
        bus.rs1      = r1;
        bus.rs2      = r2;
    endtask

    // Simple I-type: addi x1, x1, k -> {k[11:0], 0x08093}
    task automatic drive_addi(input logic [31:0] k);
        drive(1'b1, 2'd0, k, 7'h13, 3'd0, 5'd1, 5'd1, 5'd0);
    endtask

    task automatic reset_dut();
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [31:0] rand_imm();
        logic [31:0] edges [13];
        edges = '{32'd0, 32'd1, 32'd3, 32'd2047, 32'd2048, -32'sd2048, -32'sd2049,
                  32'd4094, 32'd4095, 32'd4096, -32'sd4096, -32'sd4097, -32'sd4098};
        case ($urandom_range(0, 3))
            0:       return edges[$urandom_range(0, 12)];
            1:       return 32'($urandom_range(0, 8191)) - 32'd4096;
            2:       return 32'($urandom_range(0, 4095)) - 32'd2048;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst           = 1'b1;
        cmp_en        = 1'b0;
        bus.out_ready = 1'b0;
        drive(1'b0, 2'd0, 32'd0, 7'd0, 3'd0, 5'd0, 5'd0, 5'd0);
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_instr", bus.out_instr, 32'd0);
        check("rst_out_addr", bus.out_addr, BASE);
        check("rst_out_err", 32'(bus.out_err), 32'd0);
        check("rst_err_seen", 32'(bus.err_seen), 32'd0);
        rst    = 1'b0;
        cmp_en = 1'b1;

        // I-type, one-cycle latency
        bus.out_ready = 1'b1;
        drive(1'b1, 2'd0, 32'hFFFF_FFFF, 7'h13, 3'd0, 5'd2, 5'd1, 5'd0);
        @(negedge clk);
        check("i_valid", 32'(bus.out_valid), 32'd1);
        check("i_instr", bus.out_instr, 32'hFFF0_8113);
        check("i_addr", bus.out_addr, 32'd0);
        check("i_err", 32'(bus.out_err), 32'd0);
        bus.in_valid = 1'b0;
        @(negedge clk);

        // B-type followed by S-type
        reset_dut();
        drive(1'b1, 2'd2, -32'sd8, 7'h63, 3'd1, 5'd0, 5'd5, 5'd6);
        @(negedge clk);
        check("b_instr", bus.out_instr, 32'hFE62_9CE3);
        check("b_addr", bus.out_addr, 32'd0);
        drive(1'b1, 2'd1, 32'd20, 7'h23, 3'd2, 5'd0, 5'd2, 5'd7);
        @(negedge clk);
        check("s_instr", bus.out_instr, 32'h0071_2A23);
        check("s_addr", bus.out_addr, 32'd4);
        bus.in_valid = 1'b0;
        @(negedge clk);

        // Encoding errors
        reset_dut();
        check("err_seen_clear", 32'(bus.err_seen), 32'd0);
        drive(1'b1, 2'd2, 32'd3, 7'h63, 3'd0, 5'd0, 5'd1, 5'd2);
        @(negedge clk);
        check("berr_instr", bus.out_instr, 32'h0000_0013);
        check("berr_err", 32'(bus.out_err), 32'd1);
        check("berr_seen", 32'(bus.err_seen), 32'd1);
        check("berr_addr", bus.out_addr, 32'd0);
        drive_addi(32'd2048);
        @(negedge clk);
        check("ierr_err", 32'(bus.out_err), 32'd1);
        check("ierr_instr", bus.out_instr, 32'h0000_0013);
        check("ierr_addr", bus.out_addr, 32'd4);
        bus.in_valid = 1'b0;
        @(negedge clk);

        // Backpressure: third input waits until a slot frees
        reset_dut();
        bus.out_ready = 1'b0;
        drive_addi(32'd1);
        @(negedge clk);
        check("bp_ready1", 32'(bus.in_ready), 32'd1);
        drive_addi(32'd2);
        @(negedge clk);
        check("bp_full", 32'(bus.in_ready), 32'd0);
        drive_addi(32'd3);
        @(negedge clk);
        check("bp_still_full", 32'(bus.in_ready), 32'd0);
        check("bp_head0", bus.out_addr, 32'd0);
        check("bp_head0_instr", bus.out_instr, 32'h0010_8093);
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_ready_again", 32'(bus.in_ready), 32'd1);
        check("bp_head1", bus.out_addr, 32'd4);
        @(negedge clk);
        check("bp_head2", bus.out_addr, 32'd8);
        check("bp_head2_instr", bus.out_instr, 32'h0030_8093);
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("bp_drained", 32'(bus.out_valid), 32'd0);

        // Same-cycle push and pop with one entry held
        reset_dut();
        bus.out_ready = 1'b0;
        drive_addi(32'd0);
        @(negedge clk);
        bus.out_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            drive_addi(32'(k));
            @(negedge clk);
            check("pp_valid", 32'(bus.out_valid), 32'd1);
            check("pp_ready", 32'(bus.in_ready), 32'd1);
            check("pp_addr", bus.out_addr, 32'(4 * k));
            check("pp_instr", bus.out_instr, (32'(k) << 20) | 32'h0000_8093);
        end
        bus.in_valid = 1'b0;
        @(negedge clk);

        // Reset with two entries queued overrides push and pop
        reset_dut();
        bus.out_ready = 1'b0;
        drive(1'b1, 2'd3, 32'd0, 7'h13, 3'd0, 5'd0, 5'd0, 5'd0);
        @(negedge clk);
        drive_addi(32'd7);
        @(negedge clk);
        check("mr_full", 32'(bus.in_ready), 32'd0);
        check("mr_err_seen", 32'(bus.err_seen), 32'd1);
        rst           = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("mr_out_valid", 32'(bus.out_valid), 32'd0);
        check("mr_in_ready", 32'(bus.in_ready), 32'd1);
        check("mr_err_clear", 32'(bus.err_seen), 32'd0);
        check("mr_out_instr", bus.out_instr, 32'd0);
        check("mr_out_addr", bus.out_addr, BASE);
        rst           = 1'b0;
        bus.out_ready = 1'b0;
        drive_addi(32'd5);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("mr_next_addr", bus.out_addr, BASE);
        check("mr_next_instr", bus.out_instr, 32'h0050_8093);
        bus.out_ready = 1'b1;
        @(negedge clk);

        // Randomized traffic, checked by the compare process
        for (int n = 0; n < 3000; n++) begin
            rst           = ($urandom_range(0, 199) == 0);
            bus.out_ready = ($urandom_range(0, 9) < 6);
            drive($urandom_range(0, 9) < 7, 2'($urandom_range(0, 3)), rand_imm(),
                  7'($urandom), 3'($urandom), 5'($urandom), 5'($urandom), 5'($urandom));
            @(negedge clk);
        end
        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (4) @(negedge clk);
        check("final_empty", 32'(bus.out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
